// File: rtl/ahb_slave_mem_stub_pkg.sv
// ahb_slave_mem_stub_pkg
// Shared constants, types and helpers for the AHB slave memory-side stub.
//   ADDR_BITS / DATA_BITS / MEM_WORDS : geometry of the stub (DATA_BITS is 32 or 64,
//                                       MEM_WORDS is a power of two)
//   BSEL_BITS, OFF, IDX_BITS          : derived lane count, byte-offset width, index width
//   lane_merge()                      : byte-lane merge used by both the RAM write path
//                                       and the same-word collision bypass
package ahb_slave_mem_stub_pkg;

    localparam int ADDR_BITS = 24;
    localparam int DATA_BITS = 32;
    localparam int MEM_WORDS = 1024;

    localparam int BSEL_BITS = DATA_BITS / 8;
    localparam int OFF       = $clog2(BSEL_BITS);
    localparam int IDX_BITS  = $clog2(MEM_WORDS);
    // First address bit that lies beyond the stub's word range.
    localparam int IDX_TOP   = OFF + IDX_BITS;

    typedef logic [ADDR_BITS-1:0] addr_t;
    typedef logic [DATA_BITS-1:0] data_t;
    typedef logic [BSEL_BITS-1:0] bsel_t;
    typedef logic [IDX_BITS-1:0]  idx_t;

    // Lanes with bsel[n]=1 take new_w, the others keep old_w.
    function automatic data_t lane_merge(input data_t old_w, input data_t new_w, input bsel_t bsel);
        data_t merged;
        merged = old_w;
        for (int n = 0; n < BSEL_BITS; n++) begin
            if (bsel[n]) begin
                merged[n*8 +: 8] = new_w[n*8 +: 8];
            end
        end
        return merged;
    endfunction

    // Word index: byte-offset bits dropped, bits above the range dropped (aliasing).
    function automatic idx_t word_idx(input addr_t addr);
        return addr[OFF +: IDX_BITS];
    endfunction

    // True when any address bit at or above IDX_TOP is set.
    function automatic logic addr_oor(input addr_t addr);
        return (addr >> IDX_TOP) != '0;
    endfunction

endpackage

// File: rtl/ahb_slave_mem_stub_ram.sv
// ahb_slave_mem_stub_ram
// Single-clock, one-write/one-read synchronous RAM with byte-lane write enables.
//   clk      : clock, rising edge
//   i_we     : write enable (already qualified by reset in the top)
//   i_waddr  : write word index
//   i_wdata  : write data
//   i_wbsel  : byte-lane enables for the write
//   i_re     : read enable (already qualified by reset in the top)
//   i_raddr  : read word index
//   o_rdata  : registered read data; holds while i_re=0.
// A read and write to the same index in one cycle returns the old word; the top
// level patches the write data in afterwards. The array itself is never reset.
module ahb_slave_mem_stub_ram
    import ahb_slave_mem_stub_pkg::*;
(
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [IDX_BITS-1:0]  i_waddr,
    input  logic [DATA_BITS-1:0] i_wdata,
    input  logic [BSEL_BITS-1:0] i_wbsel,
    input  logic                 i_re,
    input  logic [IDX_BITS-1:0]  i_raddr,
    output logic [DATA_BITS-1:0] o_rdata
);

    data_t r_mem [MEM_WORDS];
    data_t r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= lane_merge(r_mem[i_waddr], i_wdata, i_wbsel);
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ahb_slave_mem_stub.sv
// ahb_slave_mem_stub
// Memory responder for the AHB slave's memory-side port. Accepts single-cycle
// WR/RD strobes and returns read data one cycle after RD.
//   clk, reset          : clock and synchronous active-high reset
//   WR, ADDR_WR, DIN,
//   BSEL                : write beat (byte address, data, byte-lane enables)
//   RD, ADDR_RD         : read beat (byte address)
//   DOUT                : read data, valid the cycle after RD, held otherwise
//   WR_CNT, RD_CNT      : accepted write / read beats, wrap modulo 2^32
//   COLL                : sticky, WR and RD hit the same word in one cycle
//   OOR                 : sticky, a strobe addressed beyond MEM_WORDS
module ahb_slave_mem_stub
    import ahb_slave_mem_stub_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 WR,
    input  logic [ADDR_BITS-1:0] ADDR_WR,
    input  logic [DATA_BITS-1:0] DIN,
    input  logic [BSEL_BITS-1:0] BSEL,
    input  logic                 RD,
    input  logic [ADDR_BITS-1:0] ADDR_RD,
    output logic [DATA_BITS-1:0] DOUT,
    output logic [31:0]          WR_CNT,
    output logic [31:0]          RD_CNT,
    output logic                 COLL,
    output logic                 OOR
);

    logic  w_wr_en;
    logic  w_rd_en;
    logic  w_same_word;
    idx_t  w_wr_idx;
    idx_t  w_rd_idx;
    data_t w_ram_q;

    // r_dout_zero masks the (unreset) RAM output register until the first read
    // after reset, so DOUT reads 0 even if a read was in flight when reset hit.
    logic        r_dout_zero;
    // Collision bypass: remember the write that raced the last read and merge
    // it over the RAM's old-data output.
    logic        r_byp;
    data_t       r_byp_din;
    bsel_t       r_byp_bsel;
    logic [31:0] r_wr_cnt;
    logic [31:0] r_rd_cnt;
    logic        r_coll;
    logic        r_oor;

    assign w_wr_idx    = word_idx(ADDR_WR);
    assign w_rd_idx    = word_idx(ADDR_RD);
    // Strobes during reset must not touch the array or the read register.
    assign w_wr_en     = WR & ~reset;
    assign w_rd_en     = RD & ~reset;
    assign w_same_word = WR & RD & (w_wr_idx == w_rd_idx);

    ahb_slave_mem_stub_ram u_ram (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (w_wr_idx),
        .i_wdata (DIN),
        .i_wbsel (BSEL),
        .i_re    (w_rd_en),
        .i_raddr (w_rd_idx),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout_zero <= 1'b1;
            r_byp       <= 1'b0;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_coll      <= 1'b0;
            r_oor       <= 1'b0;
        end else begin
            if (WR) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
            if (RD) begin
                r_rd_cnt    <= r_rd_cnt + 32'd1;
                r_dout_zero <= 1'b0;
                r_byp       <= w_same_word;
                r_byp_din   <= DIN;
                r_byp_bsel  <= BSEL;
            end
            if (w_same_word) begin
                r_coll <= 1'b1;
            end
            if ((WR && addr_oor(ADDR_WR)) || (RD && addr_oor(ADDR_RD))) begin
                r_oor <= 1'b1;
            end
        end
    end

    // Output mux is driven only by registers, so no input reaches DOUT
    // combinationally; bypass state only changes on RD, so DOUT holds.
    always_comb begin
        DOUT = w_ram_q;
        if (r_byp) begin
            DOUT = lane_merge(w_ram_q, r_byp_din, r_byp_bsel);
        end
        if (r_dout_zero) begin
            DOUT = '0;
        end
    end

    assign WR_CNT = r_wr_cnt;
    assign RD_CNT = r_rd_cnt;
    assign COLL   = r_coll;
    assign OOR    = r_oor;

endmodule

// File: tb/tb_ahb_slave_mem_stub.sv
// Self-checking bench for ahb_slave_mem_stub (default geometry: 24-bit address,
// 32-bit data, 1024 words). A reference model predicts every output; read
// results go through a scoreboard queue. A vector table carries hand-computed
// read data for the directed cases.
module tb_ahb_slave_mem_stub;

    logic        clk = 1'b0;
    logic        reset;
    logic        WR;
    logic [23:0] ADDR_WR;
    logic [31:0] DIN;
    logic [3:0]  BSEL;
    logic        RD;
    logic [23:0] ADDR_RD;
    logic [31:0] DOUT;
    logic [31:0] WR_CNT;
    logic [31:0] RD_CNT;
    logic        COLL;
    logic        OOR;

    ahb_slave_mem_stub dut (
        .clk     (clk),
        .reset   (reset),
        .WR      (WR),
        .ADDR_WR (ADDR_WR),
        .DIN     (DIN),
        .BSEL    (BSEL),
        .RD      (RD),
        .ADDR_RD (ADDR_RD),
        .DOUT    (DOUT),
        .WR_CNT  (WR_CNT),
        .RD_CNT  (RD_CNT),
        .COLL    (COLL),
        .OOR     (OOR)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] mem_m [1024];
    logic [31:0] sb_q [$];
    logic [31:0] exp_dout;
    logic [31:0] exp_wr;
    logic [31:0] exp_rd;
    logic        exp_coll;
    logic        exp_oor;

    int n_checks = 0;
    int n_errors = 0;
    int n_step   = 0;

    typedef struct {
        bit          wr;
        logic [23:0] aw;
        logic [31:0] d;
        logic [3:0]  b;
        bit          rd;
        logic [23:0] ar;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [17];

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r[i*8 +: 8] = n[i*8 +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (step %0d)", name, act, exp, n_step);
        end
    endtask

    // One bus cycle: drive at the negedge, predict, let the posedge sample,
    // compare 1 time unit later, then return at the following negedge.
    task automatic step(input bit rst, input bit wr, input logic [23:0] aw, input logic [31:0] d,
                        input logic [3:0] b, input bit rd, input logic [23:0] ar);
        logic [31:0] e;
        reset = rst; WR = wr; ADDR_WR = aw; DIN = d; BSEL = b; RD = rd; ADDR_RD = ar;
        if (rst) begin
            exp_wr = 0; exp_rd = 0; exp_coll = 0; exp_oor = 0; exp_dout = 0;
            sb_q.delete();
        end else begin
            if (rd) begin
                e = mem_m[ar[11:2]];
                if (wr && aw[11:2] == ar[11:2]) begin
                    e = mrg(e, d, b);
                    exp_coll = 1'b1;
                end
                sb_q.push_back(e);
                exp_rd = exp_rd + 32'd1;
                if (ar[23:12] != 0) exp_oor = 1'b1;
            end
            if (wr) begin
                mem_m[aw[11:2]] = mrg(mem_m[aw[11:2]], d, b);
                exp_wr = exp_wr + 32'd1;
                if (aw[23:12] != 0) exp_oor = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) exp_dout = sb_q.pop_front();
        $display("step %0d rst=%0b wr=%0b aw=%h d=%h b=%h rd=%0b ar=%h -> dout=%h wcnt=%0d rcnt=%0d coll=%0b oor=%0b",
                 n_step, rst, wr, aw, d, b, rd, ar, DOUT, WR_CNT, RD_CNT, COLL, OOR);
        chk("dout", DOUT, exp_dout);
        chk("wr_cnt", WR_CNT, exp_wr);
        chk("rd_cnt", RD_CNT, exp_rd);
        chk("coll", {31'd0, COLL}, {31'd0, exp_coll});
        chk("oor", {31'd0, OOR}, {31'd0, exp_oor});
        n_step++;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 24'h0, 32'h0, 4'h0, 1'b0, 24'h0);
    endtask

    initial begin
        reset = 1'b1; WR = 1'b0; ADDR_WR = '0; DIN = '0; BSEL = '0; RD = 1'b0; ADDR_RD = '0;
        exp_dout = 0; exp_wr = 0; exp_rd = 0; exp_coll = 0; exp_oor = 0;
        for (int i = 0; i < 1024; i++) mem_m[i] = 32'h0;

        //           wr  aw          d             b     rd  ar          chk exp
        tbl[0]  = '{1, 24'h000010, 32'hDEADBEEF, 4'hF, 0, 24'h000000, 0, 32'h0};
        tbl[1]  = '{0, 24'h000000, 32'h00000000, 4'h0, 1, 24'h000010, 1, 32'hDEADBEEF};
        tbl[2]  = '{1, 24'h000020, 32'h11223344, 4'hF, 0, 24'h000000, 0, 32'h0};
        tbl[3]  = '{1, 24'h000020, 32'hAABBCCDD, 4'h5, 0, 24'h000000, 0, 32'h0};
        tbl[4]  = '{0, 24'h000000, 32'h00000000, 4'h0, 1, 24'h000020, 1, 32'h11BB33DD};
        tbl[5]  = '{1, 24'h000030, 32'h00000000, 4'hF, 0, 24'h000000, 0, 32'h0};
        tbl[6]  = '{1, 24'h000030, 32'hFFFF0000, 4'hC, 1, 24'h000031, 1, 32'hFFFF0000};
        tbl[7]  = '{1, 24'h000000, 32'h00000001, 4'hF, 0, 24'h000000, 0, 32'h0};
        tbl[8]  = '{1, 24'h000004, 32'h00000002, 4'hF, 0, 24'h000000, 0, 32'h0};
        tbl[9]  = '{1, 24'h000008, 32'h00000003, 4'hF, 0, 24'h000000, 0, 32'h0};
        tbl[10] = '{0, 24'h000000, 32'h00000000, 4'h0, 1, 24'h000000, 1, 32'h00000001};
        tbl[11] = '{0, 24'h000000, 32'h00000000, 4'h0, 1, 24'h000004, 1, 32'h00000002};
        tbl[12] = '{0, 24'h000000, 32'h00000000, 4'h0, 1, 24'h000008, 1, 32'h00000003};
        tbl[13] = '{0, 24'h000000, 32'h00000000, 4'h0, 0, 24'h000000, 1, 32'h00000003};
        tbl[14] = '{1, 24'h000044, 32'h77777777, 4'h0, 0, 24'h000000, 1, 32'h00000003};
        tbl[15] = '{1, 24'h001000, 32'h5A5A5A5A, 4'hF, 0, 24'h000000, 0, 32'h0};
        tbl[16] = '{0, 24'h000000, 32'h00000000, 4'h0, 1, 24'h000000, 1, 32'h5A5A5A5A};

        @(negedge clk);
        step(1'b1, 1'b0, 24'h0, 32'h0, 4'h0, 1'b0, 24'h0);
        step(1'b1, 1'b0, 24'h0, 32'h0, 4'h0, 1'b0, 24'h0);
        chk("reset_dout", DOUT, 32'h0);

        for (int i = 0; i < 17; i++) begin
            step(1'b0, tbl[i].wr, tbl[i].aw, tbl[i].d, tbl[i].b, tbl[i].rd, tbl[i].ar);
            if (tbl[i].chk) chk($sformatf("tbl%0d_dout", i), DOUT, tbl[i].exp);
            if (i == 1) begin
                chk("first_wr_cnt", WR_CNT, 32'd1);
                chk("first_rd_cnt", RD_CNT, 32'd1);
            end
            if (i == 6) chk("coll_set", {31'd0, COLL}, 32'd1);
            if (i == 15) chk("oor_set", {31'd0, OOR}, 32'd1);
        end
        chk("coll_sticky", {31'd0, COLL}, 32'd1);

        // Reset mid-operation: read in flight, then a reset cycle carrying
        // strobes that must be ignored, then memory must still hold its data.
        step(1'b0, 1'b0, 24'h0, 32'h0, 4'h0, 1'b1, 24'h000020);
        chk("pre_reset_dout", DOUT, 32'h11BB33DD);
        step(1'b0, 1'b0, 24'h0, 32'h0, 4'h0, 1'b1, 24'h000010);
        step(1'b1, 1'b1, 24'h000010, 32'h12345678, 4'hF, 1'b1, 24'h000010);
        chk("rst_dout", DOUT, 32'h0);
        chk("rst_wr_cnt", WR_CNT, 32'h0);
        chk("rst_rd_cnt", RD_CNT, 32'h0);
        chk("rst_flags", {30'd0, COLL, OOR}, 32'h0);
        idle();
        chk("rst_dout_hold", DOUT, 32'h0);
        step(1'b0, 1'b0, 24'h0, 32'h0, 4'h0, 1'b1, 24'h000010);
        chk("post_reset_mem", DOUT, 32'hDEADBEEF);

        // Randomised traffic over 16 words, with aliased out-of-range addresses.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 24'h000100 + 24'(i * 4), $urandom, 4'hF, 1'b0, 24'h0);
        for (int i = 0; i < 60; i++) begin
            logic [23:0] aw;
            logic [23:0] ar;
            aw = 24'h000100 + 24'($urandom_range(0, 15) * 4) + 24'($urandom_range(0, 3));
            ar = 24'h000100 + 24'($urandom_range(0, 15) * 4) + 24'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) ar = aw;
            if ($urandom_range(0, 9) == 0) aw = aw | 24'h004000;
            if ($urandom_range(0, 9) == 0) ar = ar | 24'h010000;
            step(1'b0, 1'($urandom_range(0, 1)), aw, $urandom, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), ar);
        end

        // Counter wrap: preload the write counter with all ones.
        force dut.r_wr_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_wr_cnt;
        exp_wr = 32'hFFFF_FFFF;
        step(1'b0, 1'b1, 24'h000100, 32'h0, 4'h0, 1'b0, 24'h0);
        chk("wr_cnt_wrap", WR_CNT, 32'h0);
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
